// File: rtl/fifo_stream_reader.sv
// Read-side burst controller: pops iLen words from a 1-cycle-latency FIFO and
// streams them out over valid/ready through a 3-entry skid buffer.
module fifo_stream_reader #(
  parameter int BITWIDTH = 8,
  parameter int LENWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic [LENWIDTH-1:0] iLen,
  input  logic                iClr,
  output logic                oBusy,
  output logic                oDone,
  output logic                oFifoRd,
  input  logic                iFifoEmpty,
  input  logic [BITWIDTH-1:0] iFifoData,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic [LENWIDTH-1:0] oCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [LENWIDTH-1:0]         r_len, r_issued, r_count;
  logic                        r_inflight;
  logic [2:0][BITWIDTH-1:0]    r_buf;
  logic [1:0]                  r_rd_ptr, r_wr_ptr, r_occ;
  logic                        w_room, w_pop, w_valid, w_hs, w_last;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pop only depends on registered state and the FIFO flag, never on iReady.
  always_comb begin
    w_room  = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3;
    w_pop   = (r_state == S_RUN) && !iFifoEmpty && (r_issued < r_len) && w_room;
    w_valid = (r_occ != 2'd0);
    w_hs    = w_valid && iReady;
    w_last  = w_hs && ((r_count + LENWIDTH'(1)) == r_len);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iStart) w_state_nxt = (iLen == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (iClr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_buf      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (iClr) begin
        // Dropping the in-flight flag discards the word still on its way.
        r_issued   <= '0;
        r_count    <= '0;
        r_inflight <= 1'b0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_occ      <= '0;
      end else begin
        r_inflight <= w_pop;
        if (r_state == S_IDLE && iStart) begin
          r_len    <= iLen;
          r_issued <= '0;
          r_count  <= '0;
        end else begin
          if (w_pop) r_issued <= r_issued + LENWIDTH'(1);
          if (w_hs && r_count != r_len) r_count <= r_count + LENWIDTH'(1);
        end
        if (r_inflight) begin
          r_buf[r_wr_ptr] <= iFifoData;
          r_wr_ptr        <= f_inc(r_wr_ptr);
        end
        if (w_hs) r_rd_ptr <= f_inc(r_rd_ptr);
        case ({r_inflight, w_hs})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign oBusy   = (r_state == S_RUN);
  assign oDone   = (r_state == S_DONE);
  assign oFifoRd = w_pop;
  assign oValid  = w_valid;
  assign oData   = w_valid ? r_buf[r_rd_ptr] : '0;
  assign oCount  = r_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;
  localparam int BW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          iRst, iStart, iClr;
  logic [LW-1:0] iLen;
  logic          oBusy, oDone, oFifoRd, iFifoEmpty, oValid;
  logic          iReady = 1'b1;
  logic [BW-1:0] oData;
  logic [LW-1:0] oCount;
  logic [BW-1:0] frd = '0;

  fifo_stream_reader #(.BITWIDTH(BW), .LENWIDTH(LW)) dut (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iLen(iLen), .iClr(iClr),
    .oBusy(oBusy), .oDone(oDone), .oFifoRd(oFifoRd), .iFifoEmpty(iFifoEmpty),
    .iFifoData(frd), .oValid(oValid), .iReady(iReady), .oData(oData),
    .oCount(oCount)
  );

  // FIFO model: read data appears the cycle after a pop.
  logic [7:0] fq[$];
  int         fcount = 0;
  logic       fpush = 1'b0, fflush = 1'b0;
  logic [7:0] fdata = '0;
  always @(posedge clk) begin
    if (fflush) fq.delete();
    else begin
      if (oFifoRd && fq.size() > 0) frd <= fq.pop_front();
      if (fpush) fq.push_back(fdata);
    end
    fcount <= fq.size();
  end
  assign iFifoEmpty = (fcount == 0);

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       iReady = 1'b1;
      1:       iReady = ~iReady;
      default: iReady = 1'b0;
    endcase
  end

  // Stream monitor: captures delivered words and protocol violations.
  logic [7:0] rxq[$];
  int   npop = 0, ndone = 0, rd_empty = 0, unstable = 0, overcap = 0, outst = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int   o;
  always @(negedge clk) begin
    if (!iRst) begin
      o = oBusy ? outst : 0;
      if (oFifoRd) begin
        npop <= npop + 1;
        o = o + 1;
        if (iFifoEmpty) rd_empty <= rd_empty + 1;
      end
      if (o > 3) overcap <= overcap + 1;
      if (oValid && iReady) begin
        rxq.push_back(oData);
        o = o - 1;
      end
      if (prev_stall && (!oValid || oData !== prev_data)) unstable <= unstable + 1;
      if (oDone) ndone <= ndone + 1;
      outst      <= o;
      prev_stall <= oValid && !iReady;
      prev_data  <= oData;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    @(posedge clk); #1;
    fpush = 1'b1; fdata = v;
    @(posedge clk); #1;
    fpush = 1'b0;
  endtask

  task automatic flush();
    @(posedge clk); #1 fflush = 1'b1;
    @(posedge clk); #1 fflush = 1'b0;
  endtask

  task automatic start(input logic [LW-1:0] len);
    @(posedge clk); #1;
    iStart = 1'b1; iLen = len;
    @(posedge clk); #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int len);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (oDone) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("done_count", oCount, len);
    @(negedge clk);
    chk("done_one_cycle", oDone, 0);
  endtask

  logic [7:0] tp, tv, td, h0, h1;
  logic [LW-1:0] cnt6;
  int base, p0, d0;

  initial begin
    iRst = 1'b1; iStart = 1'b1; iLen = 8'd3; iClr = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(11 * i));
    @(negedge clk);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_fiford", oFifoRd, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_count", oCount, 0);
    chk("rst_data", oData, 0);
    chk("rst_fifo_full", fcount, 8);

    // Full-rate burst of 4 using the start held through reset release
    @(posedge clk); #1;
    iRst = 1'b0; iStart = 1'b1; iLen = 8'd4;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tp[k] = oFifoRd; tv[k] = oValid; td[k] = oDone;
      if (k == 6) cnt6 = oCount;
    end
    chk("burst_pop_trace", tp, 8'b0000_1111);
    chk("burst_valid_trace", tv, 8'b0011_1100);
    chk("burst_done_trace", td, 8'b0100_0000);
    chk("burst_count", cnt6, 4);
    chk("burst_nwords", rxq.size(), 4);
    for (int i = 0; i < 4; i++) chk("burst_data", rxq[i], 11 * (i + 1));
    chk("burst_fifo_left", fcount, 4);
    chk("burst_count_hold", oCount, 4);

    // Backpressure with alternating ready
    flush();
    for (int i = 1; i <= 5; i++) push(8'(11 * i));
    rdy_mode = 1;
    base = rxq.size();
    start(5);
    wait_done(60, 5);
    rdy_mode = 0;
    chk("bp_nwords", rxq.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("bp_data", rxq[base + i], 11 * (i + 1));
    chk("bp_stable", unstable, 0);
    chk("bp_occupancy", overcap, 0);

    // FIFO runs dry mid-burst
    flush();
    push(8'd101); push(8'd102);
    base = rxq.size();
    start(4);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_two_words", rxq.size() - base, 2);
    chk("stall_busy", oBusy, 1);
    chk("stall_no_valid", oValid, 0);
    push(8'd103); push(8'd104);
    wait_done(40, 4);
    chk("stall_nwords", rxq.size() - base, 4);
    chk("stall_data2", rxq[base + 2], 103);
    chk("stall_data3", rxq[base + 3], 104);

    // Zero-length burst
    push(8'd7);
    p0 = npop;
    start(0);
    @(negedge clk);
    chk("zero_done", oDone, 1);
    chk("zero_count", oCount, 0);
    chk("zero_busy", oBusy, 0);
    @(negedge clk);
    chk("zero_done_off", oDone, 0);
    chk("zero_no_pop", npop - p0, 0);

    // Start while busy is ignored
    flush();
    for (int i = 1; i <= 5; i++) push(8'(i));
    p0 = npop;
    base = rxq.size();
    start(3);
    iStart = 1'b1; iLen = 8'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    iStart = 1'b0;
    wait_done(30, 3);
    repeat (4) @(negedge clk);
    chk("busy_pops", npop - p0, 3);
    chk("busy_nwords", rxq.size() - base, 3);
    chk("busy_fifo_left", fcount, 2);
    chk("busy_idle", oBusy, 0);

    // Abort after two handshakes
    flush();
    for (int i = 1; i <= 8; i++) push(8'(60 + i));
    d0 = ndone;
    base = rxq.size();
    start(6);
    for (int i = 0; i < 20 && rxq.size() < base + 2; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_two_hs", rxq.size() - base, 2);
    iClr = 1'b1;
    @(negedge clk);
    chk("abort_buffered", oValid, 1);
    @(posedge clk); #1;
    iClr = 1'b0;
    @(negedge clk);
    chk("abort_valid", oValid, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_count", oCount, 0);
    chk("abort_no_done", oDone, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done_later", ndone - d0, 0);
    chk("abort_fifo_left", (fq.size() >= 2), 1);
    h0 = fq[0]; h1 = fq[1];
    base = rxq.size();
    start(2);
    wait_done(30, 2);
    chk("restart_nwords", rxq.size() - base, 2);
    chk("restart_data0", rxq[base], h0);
    chk("restart_data1", rxq[base + 1], h1);

    chk("never_pop_empty", rd_empty, 0);
    chk("never_overcap", overcap, 0);
    chk("never_unstable", unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
